// File: rtl/regfile_alu_pkg.sv
// Shared encodings for the LEGv8 register-file/ALU pipe: ALU control codes,
// R-type opcode fields and main-control ALUOp classes.
package regfile_alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_ORR     = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_PASSB   = 4'b0111;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;

  localparam logic [1:0] ALUOP_LDST  = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ALU control decode: maps the main-control ALUOp class and the R-type opcode
// field onto a 4-bit ALU operation, flagging anything undecodable.
module alu_ctrl_decode
  import regfile_alu_pkg::*;
(
  input  logic [1:0]  alu_op,
  input  logic [10:0] opcode_field,
  output logic [3:0]  alu_operation,
  output logic        illegal
);

  always_comb begin
    // NOTE: outputs get a default before the case so every path assigns them and no latch is inferred.
    alu_operation = ALU_ILLEGAL;
    illegal       = 1'b1;
    case (alu_op)
      ALUOP_LDST: begin
        alu_operation = ALU_ADD;
        illegal       = 1'b0;
      end
      ALUOP_CBZ: begin
        alu_operation = ALU_PASSB;
        illegal       = 1'b0;
      end
      ALUOP_RTYPE: begin
        case (opcode_field)
          OPC_ADD: begin alu_operation = ALU_ADD; illegal = 1'b0; end
          OPC_SUB: begin alu_operation = ALU_SUB; illegal = 1'b0; end
          OPC_AND: begin alu_operation = ALU_AND; illegal = 1'b0; end
          OPC_ORR: begin alu_operation = ALU_ORR; illegal = 1'b0; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_alu_pipe.sv
// Register file fused with a 2-stage ALU execute pipe: issue/read/decode, then
// execute with internal writeback, EX->issue forwarding and a hardwired zero register.
module regfile_alu_pipe
  import regfile_alu_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = NUM_REGS - 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic              RegWrite,
  input  logic [1:0]        ALUOp,
  input  logic [10:0]       Opcode_field,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_waddr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] ALU_result,
  output logic              Zero,
  output logic [3:0]        ALU_operation,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  output logic              illegal_op
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              ex_valid_q, ex_valid_d;
  logic              ex_regwrite_q, ex_regwrite_d;
  logic              ex_illegal_q, ex_illegal_d;
  logic [3:0]        ex_op_q, ex_op_d;
  logic [ADDR_W-1:0] ex_dest_q, ex_dest_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;

  logic              out_valid_q, out_valid_d, zero_q, zero_d, illegal_q, illegal_d;
  logic [3:0]        alu_operation_q, alu_operation_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d, data1_q, data1_d, data2_q, data2_d;

  logic              accept, wb_en;
  logic [3:0]        dec_op;
  logic              dec_illegal;
  logic [DATA_W-1:0] ex_result, rd1, rd2;

  assign in_ready = !ext_we;
  assign accept   = in_valid && in_ready;

  alu_ctrl_decode u_decode (
    .alu_op        (ALUOp),
    .opcode_field  (Opcode_field),
    .alu_operation (dec_op),
    .illegal       (dec_illegal)
  );

  always_comb begin
    ex_result = '0;
    case (ex_op_q)
      ALU_AND:   ex_result = ex_a_q & ex_b_q;
      ALU_ORR:   ex_result = ex_a_q | ex_b_q;
      ALU_ADD:   ex_result = ex_a_q + ex_b_q;
      ALU_SUB:   ex_result = ex_a_q - ex_b_q;
      ALU_PASSB: ex_result = ex_b_q;
      ALU_NOR:   ex_result = ~(ex_a_q | ex_b_q);
      default:   ex_result = '0;
    endcase
  end

  // Illegal ops never write back, so they must not forward either.
  assign wb_en = ex_valid_q && ex_regwrite_q && !ex_illegal_q && (ex_dest_q != ZERO_ADDR);

  always_comb begin
    rd1 = regs_q[Read1];
    rd2 = regs_q[Read2];
    if (wb_en && ex_dest_q == Read1) rd1 = ex_result;
    if (wb_en && ex_dest_q == Read2) rd2 = ex_result;
    if (Read1 == ZERO_ADDR) rd1 = '0;
    if (Read2 == ZERO_ADDR) rd2 = '0;
  end

  // EX writeback is applied after the external load so it wins on an address clash.
  always_comb begin
    regs_d = regs_q;
    if (ext_we && ext_waddr != ZERO_ADDR) regs_d[ext_waddr] = ext_wdata;
    if (wb_en) regs_d[ex_dest_q] = ex_result;
  end

  always_comb begin
    ex_valid_d    = accept;
    ex_regwrite_d = ex_regwrite_q;
    ex_illegal_d  = ex_illegal_q;
    ex_op_d       = ex_op_q;
    ex_dest_d     = ex_dest_q;
    ex_a_d        = ex_a_q;
    ex_b_d        = ex_b_q;
    if (accept) begin
      ex_regwrite_d = RegWrite;
      ex_illegal_d  = dec_illegal;
      ex_op_d       = dec_op;
      ex_dest_d     = WriteReg;
      ex_a_d        = rd1;
      ex_b_d        = rd2;
    end
  end

  always_comb begin
    out_valid_d     = ex_valid_q;
    alu_result_d    = alu_result_q;
    zero_d          = zero_q;
    alu_operation_d = alu_operation_q;
    data1_d         = data1_q;
    data2_d         = data2_q;
    illegal_d       = illegal_q;
    if (ex_valid_q) begin
      alu_result_d    = ex_result;
      zero_d          = (ex_result == '0);
      alu_operation_d = ex_op_q;
      data1_d         = ex_a_q;
      data2_d         = ex_b_q;
      illegal_d       = ex_illegal_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the register array is reset too, since every register must read 0 after reset.
      regs_q          <= '{default: '0};
      ex_valid_q      <= 1'b0;
      ex_regwrite_q   <= 1'b0;
      ex_illegal_q    <= 1'b0;
      ex_op_q         <= '0;
      ex_dest_q       <= '0;
      ex_a_q          <= '0;
      ex_b_q          <= '0;
      out_valid_q     <= 1'b0;
      alu_result_q    <= '0;
      zero_q          <= 1'b0;
      alu_operation_q <= '0;
      data1_q         <= '0;
      data2_q         <= '0;
      illegal_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      regs_q          <= regs_d;
      ex_valid_q      <= ex_valid_d;
      ex_regwrite_q   <= ex_regwrite_d;
      ex_illegal_q    <= ex_illegal_d;
      ex_op_q         <= ex_op_d;
      ex_dest_q       <= ex_dest_d;
      ex_a_q          <= ex_a_d;
      ex_b_q          <= ex_b_d;
      out_valid_q     <= out_valid_d;
      alu_result_q    <= alu_result_d;
      zero_q          <= zero_d;
      alu_operation_q <= alu_operation_d;
      data1_q         <= data1_d;
      data2_q         <= data2_d;
      illegal_q       <= illegal_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign ALU_result    = alu_result_q;
  assign Zero          = zero_q;
  assign ALU_operation = alu_operation_q;
  assign Data1         = data1_q;
  assign Data2         = data2_q;
  assign illegal_op    = illegal_q;

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Scoreboard bench for regfile_alu_pipe: directed instructions push hand-computed
// results; a negedge monitor pops and compares whenever out_valid is high.
module tb_regfile_alu_pipe;
  import regfile_alu_pkg::*;

  localparam logic [63:0] P5  = 64'h5555_5555_5555_5555;
  localparam logic [63:0] PA  = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] PF  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PAB = 64'hAAAA_AAAA_AAAA_AAAB;
  localparam logic [4:0]  XZR = 5'd31;

  logic        clock, reset_n, in_valid, in_ready, RegWrite, ext_we;
  logic [4:0]  Read1, Read2, WriteReg, ext_waddr;
  logic [1:0]  ALUOp;
  logic [10:0] Opcode_field;
  logic [63:0] ext_wdata, ALU_result, Data1, Data2;
  logic        out_valid, Zero, illegal_op;
  logic [3:0]  ALU_operation;

  regfile_alu_pipe dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .Read1(Read1), .Read2(Read2), .WriteReg(WriteReg), .RegWrite(RegWrite),
    .ALUOp(ALUOp), .Opcode_field(Opcode_field), .ext_we(ext_we),
    .ext_waddr(ext_waddr), .ext_wdata(ext_wdata), .out_valid(out_valid),
    .ALU_result(ALU_result), .Zero(Zero), .ALU_operation(ALU_operation),
    .Data1(Data1), .Data2(Data2), .illegal_op(illegal_op)
  );

  typedef struct {
    logic [63:0] res;
    logic [3:0]  op;
    logic [63:0] d1;
    logic [63:0] d2;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("latency_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("ALU_result", ALU_result, mon_e.res);
        check("Zero", 64'(Zero), 64'(mon_e.res == 64'd0));
        check("ALU_operation", 64'(ALU_operation), 64'(mon_e.op));
        check("Data1", Data1, mon_e.d1);
        check("Data2", Data2, mon_e.d2);
        check("illegal_op", 64'(illegal_op), 64'(mon_e.ill));
      end
    end
  end

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wr,
                       input logic rw, input logic [1:0] aop, input logic [10:0] opc,
                       input logic exp_v, input logic [63:0] eres, input logic [3:0] eop,
                       input logic [63:0] ed1, input logic [63:0] ed2, input logic eill);
    exp_t e;
    Read1 = r1; Read2 = r2; WriteReg = wr; RegWrite = rw;
    ALUOp = aop; Opcode_field = opc; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    if (exp_v) begin
      e.res = eres; e.op = eop; e.d1 = ed1; e.d2 = ed2; e.ill = eill;
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
  endtask

  // Reads a register by passing it through ALU operand B with no writeback.
  task automatic read_reg(input logic [4:0] r, input logic [63:0] v);
    issue(XZR, r, 5'd0, 1'b0, ALUOP_CBZ, 11'd0, 1'b1, v, ALU_PASSB, 64'd0, v, 1'b0);
  endtask

  task automatic ext_load(input logic [4:0] a, input logic [63:0] d);
    ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
    @(posedge clock); #1;
    ext_we = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; RegWrite = 1'b0; ext_we = 1'b0;
    Read1 = '0; Read2 = '0; WriteReg = '0; ALUOp = '0; Opcode_field = '0;
    ext_waddr = '0; ext_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_ALU_result", ALU_result, 64'd0);
    check("reset_Zero", 64'(Zero), 64'd0);
    check("reset_ALU_operation", 64'(ALU_operation), 64'd0);
    check("reset_illegal_op", 64'(illegal_op), 64'd0);
    check("reset_Data1", Data1, 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // 1: external loads then AND X1 = X5 & X10
    ext_load(5'd5, P5);
    ext_load(5'd10, PA);
    issue(5'd5, 5'd10, 5'd1, 1'b1, ALUOP_RTYPE, OPC_AND, 1'b1, 64'd0, ALU_AND, P5, PA, 1'b0);
    // 2: back-to-back ORR, ADD, SUB (latency check enforces consecutive out_valid)
    issue(5'd5, 5'd10, 5'd2, 1'b1, ALUOP_RTYPE, OPC_ORR, 1'b1, PF, ALU_ORR, P5, PA, 1'b0);
    issue(5'd5, 5'd10, 5'd3, 1'b1, ALUOP_RTYPE, OPC_ADD, 1'b1, PF, ALU_ADD, P5, PA, 1'b0);
    issue(5'd5, 5'd10, 5'd4, 1'b1, ALUOP_RTYPE, OPC_SUB, 1'b1, PAB, ALU_SUB, P5, PA, 1'b0);
    read_reg(5'd4, PAB);
    // 3: forwarding of X3 into the immediately following ADD
    issue(5'd5, 5'd5, 5'd3, 1'b1, ALUOP_RTYPE, OPC_ADD, 1'b1, PA, ALU_ADD, P5, P5, 1'b0);
    issue(5'd3, 5'd5, 5'd6, 1'b1, ALUOP_RTYPE, OPC_ADD, 1'b1, PF, ALU_ADD, PA, P5, 1'b0);
    read_reg(5'd6, PF);
    drain();

    // 4: XZR writes dropped, reads zero, never forwarded
    ext_load(XZR, 64'h1234);
    issue(XZR, 5'd5, 5'd7, 1'b1, ALUOP_RTYPE, OPC_ORR, 1'b1, P5, ALU_ORR, 64'd0, P5, 1'b0);
    issue(5'd5, 5'd5, XZR, 1'b1, ALUOP_RTYPE, OPC_ADD, 1'b1, PA, ALU_ADD, P5, P5, 1'b0);
    read_reg(XZR, 64'd0);
    read_reg(5'd7, P5);
    drain();

    // 5: illegal opcodes leave destination untouched
    issue(5'd5, 5'd10, 5'd2, 1'b1, ALUOP_RTYPE, 11'h7FF, 1'b1, 64'd0, ALU_ILLEGAL, P5, PA, 1'b1);
    issue(5'd5, 5'd10, 5'd3, 1'b1, ALUOP_RSVD, OPC_ADD, 1'b1, 64'd0, ALU_ILLEGAL, P5, PA, 1'b1);
    read_reg(5'd2, PF);
    read_reg(5'd3, PA);
    // ext_we stalls issue
    ext_we = 1'b1; ext_waddr = 5'd11; ext_wdata = 64'h77;
    Read1 = 5'd5; Read2 = 5'd5; WriteReg = 5'd12; RegWrite = 1'b1;
    ALUOp = ALUOP_LDST; in_valid = 1'b1;
    #1;
    check("in_ready_during_ext_we", 64'(in_ready), 64'd0);
    @(posedge clock); #1;
    ext_we = 1'b0; in_valid = 1'b0;
    read_reg(5'd11, 64'h77);
    read_reg(5'd12, 64'd0);
    // same-address clash: EX writeback of X9 beats external write of X9
    issue(5'd5, 5'd10, 5'd9, 1'b1, ALUOP_LDST, 11'd0, 1'b1, PF, ALU_ADD, P5, PA, 1'b0);
    ext_load(5'd9, 64'h1234);
    read_reg(5'd9, PF);
    drain();

    // 6: reset while ADD X8 is in EX discards it
    repeat (3) @(posedge clock);
    #1;
    issue(5'd5, 5'd5, 5'd8, 1'b1, ALUOP_RTYPE, OPC_ADD, 1'b0, 64'd0, 4'd0, 64'd0, 64'd0, 1'b0);
    reset_n = 1'b0;
    #2;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    read_reg(5'd8, 64'd0);
    read_reg(5'd5, 64'd0);
    read_reg(5'd10, 64'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
